// File: rtl/jpeg_izigzag_buf_if.sv
// Coefficient stream bundle for the inverse zigzag buffer: zigzag-ordered
// input side and raster-ordered output side with block framing.
interface jpeg_izigzag_buf_if #(
  parameter int unsigned DW = 12
);
  logic          din_valid;
  logic [DW-1:0] din;
  logic          din_ready;
  logic          dout_valid;
  logic [DW-1:0] dout;
  logic          dout_ready;
  logic          dout_sob;
  logic          dout_eob;

  modport master (
    output din_valid, din, dout_ready,
    input  din_ready, dout_valid, dout, dout_sob, dout_eob
  );

  modport slave (
    input  din_valid, din, dout_ready,
    output din_ready, dout_valid, dout, dout_sob, dout_eob
  );
endinterface

// File: rtl/jpeg_izigzag_buf.sv
// Inverse zigzag reorder buffer: two 64-entry ping-pong banks, written in
// zigzag order at scattered addresses and drained linearly in raster order.
module jpeg_izigzag_buf #(
  parameter int unsigned DW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  jpeg_izigzag_buf_if.slave bus
);

  // Zigzag index k -> raster position (row*8 + col) of that coefficient.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [5:0]    wcnt;
  logic [5:0]    rcnt;
  logic [DW-1:0] mem [128];

  logic          din_ready_i;
  logic          dout_valid_i;
  logic          wr_fire;
  logic          rd_fire;
  logic          wr_done;
  logic          rd_done;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;
  logic [6:0]    wr_addr;
  logic [6:0]    rd_addr;

  // Ready is forced low while rst is held so nothing is offered during reset.
  always_comb begin
    din_ready_i  = rst & ena & ~full[wr_bank];
    dout_valid_i = ena & full[rd_bank];
    wr_fire      = bus.din_valid & din_ready_i;
    rd_fire      = dout_valid_i & bus.dout_ready;
    wr_done      = wr_fire & (wcnt == 6'd63);
    rd_done      = rd_fire & (rcnt == 6'd63);
    full_set     = wr_bank ? {wr_done, 1'b0} : {1'b0, wr_done};
    full_clr     = rd_bank ? {rd_done, 1'b0} : {1'b0, rd_done};
    wr_addr      = {wr_bank, ZZ[wcnt]};
    rd_addr      = {rd_bank, rcnt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wcnt    <= '0;
      rcnt    <= '0;
    end else begin
      if (wr_fire) begin
        wcnt <= wcnt + 6'd1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rcnt <= rcnt + 6'd1;
        if (rd_done) rd_bank <= ~rd_bank;
      end
      // Set and clear always target different banks, so they compose freely.
      full <= (full | full_set) & ~full_clr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= bus.din;
  end

  always_comb begin
    bus.din_ready  = din_ready_i;
    bus.dout_valid = dout_valid_i;
    bus.dout       = dout_valid_i ? mem[rd_addr] : '0;
    bus.dout_sob   = dout_valid_i & (rcnt == 6'd0);
    bus.dout_eob   = dout_valid_i & (rcnt == 6'd63);
  end

endmodule

// File: tb/tb_jpeg_izigzag_buf.sv
// Randomised bench for jpeg_izigzag_buf against a block-level reorder model
// built from the diagonal walk of an 8x8 block.
module tb_jpeg_izigzag_buf;
  localparam int unsigned DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b1;

  jpeg_izigzag_buf_if #(.DW(DW)) bus ();

  jpeg_izigzag_buf #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int            zz[64];
  logic [DW-1:0] wblk[64];
  int            wpos = 0;
  int            rpos = 0;
  int            blocks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cap_q[$];
  bit            capture = 0;

  // Scenario control
  bit mon_on = 0;
  int wr_cnt = 0, rd_cnt = 0;
  int wr_limit = 0, rd_limit = 0;
  int wr_prob = 100, rd_prob = 100;
  bit rand_data = 0;
  bit pause_mode = 0, paused_w = 0, paused_r = 0;
  int pause_left = 0;

  bit            exp_dr, exp_dv, wf, rf;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_dout;

  always @(negedge clk) begin
    if (mon_on) begin
      if (!rst) begin
        check("rst_din_ready", bus.din_ready, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_sob_eob", {bus.dout_sob, bus.dout_eob}, 0);
        wpos = 0; rpos = 0; blocks = 0; prev_stall = 0;
        exp_q.delete();
      end else begin
        exp_dr = ena && (blocks < 2);
        exp_dv = ena && (blocks > 0);
        check("din_ready", bus.din_ready, exp_dr);
        check("dout_valid", bus.dout_valid, exp_dv);
        if (exp_dv && exp_q.size() > 0) begin
          check("dout", bus.dout, exp_q[0]);
          check("dout_sob", bus.dout_sob, rpos == 0);
          check("dout_eob", bus.dout_eob, rpos == 63);
        end else if (!exp_dv) begin
          check("dout_idle", bus.dout, 0);
          check("sob_eob_idle", {bus.dout_sob, bus.dout_eob}, 0);
        end
        if (prev_stall && bus.dout_valid)
          check("dout_stable", bus.dout, prev_dout);
        wf = bus.din_valid && bus.din_ready;
        rf = bus.dout_valid && bus.dout_ready;
        prev_stall = bus.dout_valid && !bus.dout_ready;
        prev_dout  = bus.dout;
        if (rf) begin
          if (capture) cap_q.push_back(bus.dout);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          rd_cnt++;
          rpos = (rpos + 1) % 64;
          if (rpos == 0) blocks--;
        end
        if (wf) begin
          wblk[zz[wpos]] = bus.din;
          wpos++;
          wr_cnt++;
          if (wpos == 64) begin
            wpos = 0;
            blocks++;
            for (int r = 0; r < 64; r++) exp_q.push_back(wblk[r]);
          end
        end
      end
    end
  end

  // Stimulus driver
  initial begin
    int sel;
    bus.din_valid  = 1'b0;
    bus.din        = '0;
    bus.dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pause_mode && !paused_w && wr_cnt == 30) begin paused_w = 1; pause_left = 5; end
      if (pause_mode && !paused_r && rd_cnt == 10) begin paused_r = 1; pause_left = 5; end
      if (pause_left > 0) begin
        ena = 1'b0;
        pause_left--;
      end else begin
        ena = 1'b1;
      end
      if (rand_data) begin
        sel = $urandom_range(0, 7);
        bus.din = (sel == 0) ? 12'h800 : (sel == 1) ? 12'h7FF : DW'($urandom);
      end else begin
        bus.din = DW'(wr_cnt);
      end
      bus.din_valid  = (wr_cnt < wr_limit) && ($urandom_range(0, 99) < wr_prob);
      bus.dout_ready = (rd_cnt < rd_limit) && ($urandom_range(0, 99) < rd_prob);
    end
  end

  task automatic wait_cnt(input string tag, input int wt, input int rt, input int budget);
    int n = 0;
    while ((wr_cnt < wt || rd_cnt < rt) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(tag, (wr_cnt >= wt) && (rd_cnt >= rt), 1);
  endtask

  task automatic new_scenario(input int wl, input int rl, input int wp, input int rp);
    @(posedge clk);
    #2;
    wr_cnt = 0; rd_cnt = 0;
    wr_limit = wl; rd_limit = rl;
    wr_prob = wp; rd_prob = rp;
  endtask

  int kat[10] = '{0, 1, 5, 6, 14, 15, 27, 28, 2, 4};

  initial begin
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int row = (s < 8 ? s : 7); row >= (s > 7 ? s - 7 : 0); row--) begin
          zz[k] = row * 8 + (s - row); k++;
        end
      end else begin
        for (int row = (s > 7 ? s - 7 : 0); row <= (s < 8 ? s : 7); row++) begin
          zz[k] = row * 8 + (s - row); k++;
        end
      end
    end

    mon_on = 1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Single block, known-answer raster order
    capture = 1;
    new_scenario(64, 64, 100, 100);
    wait_cnt("single_done", 64, 64, 500);
    capture = 0;
    check("single_len", cap_q.size(), 64);
    if (cap_q.size() == 64) begin
      for (int i = 0; i < 10; i++) check("single_kat", cap_q[i], kat[i]);
      check("single_last", cap_q[63], 63);
    end

    // Four blocks streamed back to back
    new_scenario(256, 256, 100, 100);
    wait_cnt("stream_done", 256, 256, 1000);

    // Output blocked: two banks fill, third block waits
    new_scenario(192, 0, 100, 100);
    wait_cnt("fill2_done", 128, 0, 1000);
    repeat (5) @(negedge clk);
    check("fill2_stall", bus.din_ready, 0);
    check("fill2_count", wr_cnt, 128);
    rd_limit = 1;
    wait_cnt("one_read", 128, 1, 100);
    @(negedge clk);
    check("one_read_full", bus.din_ready, 0);
    rd_limit = 192;
    wait_cnt("fill3_done", 192, 192, 2000);

    // Clock enable pauses at input beat 30 and output beat 10
    paused_w = 0; paused_r = 0; pause_mode = 1;
    new_scenario(128, 128, 100, 100);
    wait_cnt("pause_done", 128, 128, 1000);
    pause_mode = 0;

    // Reset mid-block with a partly drained bank
    new_scenario(104, 20, 100, 100);
    wait_cnt("pre_rst", 104, 20, 1000);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rst_immediate", bus.dout_valid, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    capture = 1;
    cap_q.delete();
    new_scenario(64, 64, 100, 100);
    wait_cnt("post_rst", 64, 64, 500);
    capture = 0;
    check("post_rst_len", cap_q.size(), 64);
    if (cap_q.size() == 64) check("post_rst_first", cap_q[0], 0);

    // Random stalls and data over 100 blocks
    rand_data = 1;
    new_scenario(6400, 6400, 50, 50);
    wait_cnt("random_done", 6400, 6400, 60000);

    repeat (4) @(posedge clk);
    check("drained", exp_q.size(), 0);
    @(negedge clk);
    check("final_idle", bus.dout_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/jpeg_izigzag_buf.md
Name: jpeg_izigzag_buf

Overview:
- Inverse zigzag reorder buffer for the decode-side datapath. It is the reader for the encoder's fdct_zigzag output ordering.
- Accepts 64 quantised DCT coefficients per 8x8 block in JPEG zigzag order and emits them in raster order (row-major, u fastest) to the IDCT MAC units.
- Uses two 64-entry ping-pong banks, so one block fills while the previous one drains. Handshake is valid/ready on both sides.

Parameters:
DW, 12, coefficient width in bits (two's complement, carried through unmodified)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
ena  in  1  global clock enable; when low, no handshake completes and all state holds
din_valid  in  1  din carries a coefficient
din  in  DW  coefficient, zigzag order, index k=0..63 within block
din_ready  out  1  buffer can accept din this cycle
dout_valid  out  1  dout carries a coefficient
dout  out  DW  coefficient, raster order, position r=0..63 within block
dout_ready  in  1  downstream accepts dout this cycle
dout_sob  out  1  dout is raster position 0 of a block (qualified by dout_valid)
dout_eob  out  1  dout is raster position 63 of a block (qualified by dout_valid)

Behaviour:
- State:
  - full[1:0]: per-bank full flags
  - wr_bank, rd_bank: 1 bit each
  - wcnt, rcnt: 6 bits each
  - storage: 2x64xDW, not reset
- Reset (rst=0, async): full=0, wr_bank=rd_bank=0, wcnt=rcnt=0. Outputs: din_ready=0 while in reset, dout_valid=0, dout=0, dout_sob=0, dout_eob=0.
- Any partially written or partially read block is discarded on reset.
- din_ready = ena & ~full[wr_bank] (combinational, no dependence on din_valid).
- Write fires when din_valid & din_ready:
  - mem[wr_bank][ZZ(wcnt)] <= din, where ZZ is the standard JPEG zigzag-to-raster map (ITU-T T.81 Fig. A.6): ZZ(0..9)=0,1,8,16,9,2,3,10,17,24; ZZ(62)=62; ZZ(63)=63.
  - wcnt increments and wraps from 63 to 0.
  - When wcnt==63 at the write: full[wr_bank]<=1 and wr_bank toggles.
- dout_valid = ena & full[rd_bank]. dout = mem[rd_bank][rcnt] when dout_valid, else 0.
- dout_sob = dout_valid & (rcnt==0). dout_eob = dout_valid & (rcnt==63).
- Read fires when dout_valid & dout_ready:
  - rcnt increments and wraps from 63 to 0.
  - When rcnt==63 at the read: full[rd_bank]<=0 and rd_bank toggles.
- Latency: a block becomes readable the cycle after its 64th coefficient is accepted. There is no write-to-read bypass within a bank.
- Throughput: 1 coefficient/cycle on each side, sustained indefinitely with both banks in use.
- Simultaneous events:
  - A write completing bank A and a read completing bank B in the same cycle both take effect.
  - The full flags are updated per bank independently; a set and a clear never target the same bank in one cycle.
- Both banks full: din_ready=0 until the current read block's 64th transfer. din_ready rises the cycle after that transfer.
- Both banks empty: dout_valid=0, and din_ready=1 when ena=1.
- ena=0: din_ready=0 and dout_valid=0. Counters, flags and storage hold. Operation resumes exactly where it paused.
- din_valid may toggle freely. dout remains stable while dout_valid & ~dout_ready.
- No range checking is done; all DW bits pass through bit-exact.

Test Plan:
- Single block, din=k for k=0..63 back-to-back, dout_ready=1 → first dout_valid one cycle after k=63 is accepted. dout sequence is 0,1,5,6,14,15,27,28,2,4,7,13,...,63. dout_sob on the first beat only, dout_eob on the 64th beat only.
- Four blocks streamed continuously (block b: din=b*64+k, DW=12), dout_ready=1 → din_ready stays 1 throughout and outputs are contiguous after the first block. Block b's raster order equals b*64 plus the single-block sequence.
- dout_ready=0 while three blocks are offered → the first two blocks are accepted, then din_ready=0 after 128 writes. One read beat leaves din_ready at 0. din_ready=1 the cycle after the 64th read of block 0.
- ena toggled low for 5 cycles at input beat 30 and output beat 10 → no transfers and no counter change during ena=0. The final output matches the uninterrupted run.
- rst asserted mid-block (after 40 writes, with 20 reads into the previous block) → dout_valid=0 immediately. After release, a fresh 64-coefficient block is output correctly, with no residual data from before reset.
- Random din_valid/dout_ready stalls (50% each) over 100 blocks with random DW-bit data, including values 0x800 and 0x7FF → output equals a reference model that reorders by ZZ. dout stays stable whenever valid=1 and ready=0.
